// File: rtl/score_pkg.sv
// Shared definitions for the score keeper.
//   state_e        : FSM state codes (IDLE=00, PLAY=01, OVER=10; 11 is illegal)
//   SCORE_W, ADD_W : datapath widths for the score and the points request
//   DEF_MAX_SCORE  : default saturation ceiling
//   DEF_PENALTY    : default points removed per penalty
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_e;

    localparam int unsigned SCORE_W       = 10;
    localparam int unsigned ADD_W         = 4;
    localparam int unsigned DEF_MAX_SCORE = 999;
    localparam int unsigned DEF_PENALTY   = 5;

endpackage

// File: rtl/score_keeper_sat_update.sv
// score_sat_update: pure combinational saturating score update.
//   score : current score (0..MAX_SCORE)
//   add   : points to add (already zeroed when no transfer)
//   sub   : remove PENALTY points this cycle
//   next  : clamp(score + add - (sub ? PENALTY : 0), 0, MAX_SCORE)
// Arithmetic is 12-bit signed so neither overflow above 1023 nor
// underflow below 0 can wrap before the clamp.
module score_sat_update
    import score_pkg::*;
#(
    parameter int unsigned MAX_SCORE = DEF_MAX_SCORE,
    parameter int unsigned PENALTY   = DEF_PENALTY
) (
    input  logic [SCORE_W-1:0] score,
    input  logic [ADD_W-1:0]   add,
    input  logic               sub,
    output logic [SCORE_W-1:0] next
);

    localparam logic signed [11:0] MAX_S = 12'(MAX_SCORE);
    localparam logic signed [11:0] PEN_S = 12'(PENALTY);

    logic signed [11:0] sum;

    always_comb begin
        sum = $signed({2'b00, score}) + $signed({8'h00, add});
        if (sub) begin
            sum = sum - PEN_S;
        end
        if (sum < 12'sd0) begin
            next = '0;
        end else if (sum > MAX_S) begin
            next = MAX_S[SCORE_W-1:0];
        end else begin
            next = sum[SCORE_W-1:0];
        end
    end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: game score FSM with saturating add/penalty and optional
// high-score tracking.
//   clk, clr_n      : clock, asynchronous active-low reset
//   new_game        : pulse, starts (or restarts) a game and clears score
//   game_over       : pulse, ends the game (new_game wins if both high)
//   add_valid/ready : points request handshake; ready only in PLAY
//   add_pts         : points to add on a transfer
//   penalty         : pulse, subtracts PENALTY while in PLAY
//   show_hi         : level, selects the high score for disp_score
//   score           : registered current score
//   disp_score      : registered display value (one cycle behind source)
//   new_hi          : one-cycle pulse when the high score is raised
//   state_o         : FSM state code for debug
// Build option: define SCORE_HISCORE_EN to implement the high score,
// new_hi and show_hi; otherwise new_hi is 0 and disp_score follows score.
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned MAX_SCORE = DEF_MAX_SCORE,
    parameter int unsigned PENALTY   = DEF_PENALTY
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               new_game,
    input  logic               game_over,
    input  logic               add_valid,
    input  logic [ADD_W-1:0]   add_pts,
    output logic               add_ready,
    input  logic               penalty,
    input  logic               show_hi,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] disp_score,
    output logic               new_hi,
    output logic [1:0]         state_o
);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] disp_q, disp_d;
    logic [SCORE_W-1:0] upd_score;
    logic [ADD_W-1:0]   add_amt;
    logic               in_play;
    logic               xfer;

`ifdef SCORE_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q, hiscore_d;
    logic               new_hi_q, new_hi_d;
`else
    logic               unused_show_hi;
    assign unused_show_hi = show_hi;
`endif

    assign in_play   = (state_q == ST_PLAY);
    assign add_ready = in_play;
    assign xfer      = add_valid & in_play;
    assign add_amt   = xfer ? add_pts : '0;

    score_sat_update #(
        .MAX_SCORE (MAX_SCORE),
        .PENALTY   (PENALTY)
    ) u_sat (
        .score (score_q),
        .add   (add_amt),
        .sub   (penalty & in_play),
        .next  (upd_score)
    );

    always_comb begin
        state_d = state_q;
        score_d = score_q;
`ifdef SCORE_HISCORE_EN
        hiscore_d = hiscore_q;
        new_hi_d  = 1'b0;
        disp_d    = show_hi ? hiscore_q : score_q;
`else
        disp_d    = score_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (new_game) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                end
            end
            ST_PLAY: begin
                // new_game restarts and takes priority over game_over
                if (new_game) begin
                    score_d = '0;
                end else begin
                    score_d = upd_score;
                    if (game_over) begin
                        state_d = ST_OVER;
`ifdef SCORE_HISCORE_EN
                        // compare the final score, including any
                        // update landing on the game_over edge
                        if (upd_score > hiscore_q) begin
                            hiscore_d = upd_score;
                            new_hi_d  = 1'b1;
                        end
`endif
                    end
                end
            end
            ST_OVER: begin
                if (new_game) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            score_q   <= '0;
            disp_q    <= '0;
`ifdef SCORE_HISCORE_EN
            hiscore_q <= '0;
            new_hi_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            disp_q    <= disp_d;
`ifdef SCORE_HISCORE_EN
            hiscore_q <= hiscore_d;
            new_hi_q  <= new_hi_d;
`endif
        end
    end

    assign score      = score_q;
    assign disp_score = disp_q;
    assign state_o    = state_q;
`ifdef SCORE_HISCORE_EN
    assign new_hi     = new_hi_q;
`else
    assign new_hi     = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper: directed scenarios followed by random
// stimulus, checked by a scoreboard against a behavioural game model.
`timescale 1ns/1ps
module tb_score_keeper;

    localparam int MAX_S = 999;
    localparam int PEN   = 5;
`ifdef SCORE_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       new_game = 1'b0;
    logic       game_over = 1'b0;
    logic       add_valid = 1'b0;
    logic [3:0] add_pts = '0;
    logic       add_ready;
    logic       penalty = 1'b0;
    logic       show_hi = 1'b0;
    logic [9:0] score;
    logic [9:0] disp_score;
    logic       new_hi;
    logic [1:0] state_o;

    score_keeper #(
        .MAX_SCORE (MAX_S),
        .PENALTY   (PEN)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .new_game   (new_game),
        .game_over  (game_over),
        .add_valid  (add_valid),
        .add_pts    (add_pts),
        .add_ready  (add_ready),
        .penalty    (penalty),
        .show_hi    (show_hi),
        .score      (score),
        .disp_score (disp_score),
        .new_hi     (new_hi),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int score;
        int disp;
        int new_hi;
        int ready;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Game model: playing/ended flags, score and best score so far.
    bit m_play = 1'b0;
    bit m_over = 1'b0;
    int m_score = 0;
    int m_hi = 0;

    task automatic check(input string name, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One clock of stimulus; the expected post-edge outputs are queued.
    task automatic step(input bit ng, input bit go, input bit av,
                        input int pts, input bit pen, input bit sh);
        exp_t e;
        int   s;
        int   old_score;
        int   old_hi;
        @(negedge clk);
        new_game  = ng;
        game_over = go;
        add_valid = av;
        add_pts   = 4'(pts);
        penalty   = pen;
        show_hi   = sh;
        old_score = m_score;
        old_hi    = m_hi;
        e.new_hi  = 0;
        if (ng) begin
            m_play  = 1'b1;
            m_over  = 1'b0;
            m_score = 0;
        end else if (m_play) begin
            s = m_score + (av ? pts : 0) - (pen ? PEN : 0);
            if (s < 0) s = 0;
            if (s > MAX_S) s = MAX_S;
            m_score = s;
            if (go) begin
                m_play = 1'b0;
                m_over = 1'b1;
                if (HI_EN && s > m_hi) begin
                    m_hi     = s;
                    e.new_hi = 1;
                end
            end
        end
        e.st    = m_play ? 1 : (m_over ? 2 : 0);
        e.score = m_score;
        e.disp  = (HI_EN && sh) ? old_hi : old_score;
        e.ready = m_play ? 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic add(input int p);
        step(1'b0, 1'b0, 1'b1, p, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 5) begin
            @(posedge clk);
            #3;
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_score"}, 32'(score), 0);
        check({tag, "_disp"}, 32'(disp_score), 0);
        check({tag, "_new_hi"}, 32'(new_hi), 0);
        check({tag, "_state"}, 32'(state_o), 0);
        check({tag, "_ready"}, 32'(add_ready), 0);
    endtask

    // Monitor: compares the DUT against the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state", 32'(state_o), e.st);
                check("score", 32'(score), e.score);
                check("disp_score", 32'(disp_score), e.disp);
                check("new_hi", 32'(new_hi), e.new_hi);
                check("add_ready", 32'(add_ready), e.ready);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, visible before any clock edge.
        #3;
        check_all_zero("reset");
        @(negedge clk);
        clr_n = 1'b1;
        idle();
        idle();

        // Basic adds: 7, 22, 25.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        add(7);
        add(15);
        add(3);
        drain();
        check("seq_score", 32'(score), 25);

        // Saturation at the ceiling.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 66; i++) add(15);
        add(6);
        drain();
        check("sat_pre", 32'(score), 996);
        add(15);
        add(1);
        drain();
        check("sat_ceiling", 32'(score), 999);

        // Penalty floor and net add+penalty.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        add(3);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        drain();
        check("pen_floor", 32'(score), 0);
        add(7);
        add(3);
        step(1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0);
        drain();
        check("add_and_pen", 32'(score), 9);

        // High score capture, display, and tie.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        add(15);
        add(15);
        add(10);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        drain();
        check("hi_disp", 32'(disp_score), 40);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        add(15);
        add(15);
        add(10);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        drain();

        // Add held off in OVER, lands after new_game.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        drain();
        check("over_ready", 32'(add_ready), 0);
        check("over_hold", 32'(score), 40);
        step(1'b1, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        drain();
        check("held_add", 32'(score), 5);

        // Asynchronous reset mid-game.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) add(15);
        drain();
        check("pre_reset", 32'(score), 120);
        @(negedge clk);
        new_game  = 1'b0;
        game_over = 1'b0;
        add_valid = 1'b0;
        penalty   = 1'b0;
        show_hi   = 1'b0;
        #2;
        clr_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        m_play  = 1'b0;
        m_over  = 1'b0;
        m_score = 0;
        m_hi    = 0;
        @(negedge clk);
        clr_n = 1'b1;
        idle();
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        drain();

        // Random play.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 19) == 0,
                 $urandom_range(0, 11) == 0,
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 5) == 0,
                 1'($urandom_range(0, 1)));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter MAX_SCORE, default 999: saturation ceiling; SHALL be ≤ 1023.
REQ-002 Parameter PENALTY, default 5: points removed per accepted penalty.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 clr_n  input  1  asynchronous, active-low reset.
REQ-005 new_game  input  1  one-cycle pulse that starts a game.
REQ-006 game_over  input  1  one-cycle pulse that ends a game.
REQ-007 add_valid  input  1  a points request is present.
REQ-008 add_pts  input  4  points to add, 0-15.
REQ-009 add_ready  output  1  high when an add is accepted this cycle.
REQ-010 penalty  input  1  one-cycle pulse that subtracts PENALTY.
REQ-011 show_hi  input  1  level; selects the high score for disp_score.
REQ-012 score  output  10  current score, binary, registered.
REQ-013 disp_score  output  10  value sent to the 7-segment display stage, registered.
REQ-014 new_hi  output  1  one-cycle pulse when the high score is updated.
REQ-015 state_o  output  2  current FSM state, for debug.

Function
REQ-016 The FSM SHALL have three states, encoded IDLE=00, PLAY=01, OVER=10; code 11 SHALL return to IDLE on the next clock.
REQ-017 IDLE -> PLAY on new_game; score SHALL clear to 0 on that same edge.
REQ-018 PLAY -> OVER on game_over.
REQ-019 OVER -> PLAY on new_game, with score cleared to 0; otherwise the FSM SHALL remain in OVER and score SHALL hold.
REQ-020 If new_game and game_over are high in the same cycle, new_game SHALL take priority.
REQ-021 add_ready SHALL equal (state==PLAY) and SHALL be combinational.
REQ-022 An add transfer occurs when add_valid && add_ready.
REQ-023 In IDLE and OVER, add requests SHALL be held off and not dropped; the requester keeps add_valid asserted.
REQ-024 Score update in PLAY: next = clamp(score + (xfer ? add_pts : 0) - (penalty ? PENALTY : 0), 0, MAX_SCORE).
REQ-025 The update SHALL be computed in 12-bit signed arithmetic; score SHALL never wrap.
REQ-026 The new score SHALL appear on score exactly 1 cycle after the transfer or penalty edge.
REQ-027 A simultaneous add and penalty SHALL be applied as a single net update in one cycle.
REQ-028 A penalty outside PLAY SHALL be ignored.
REQ-029 disp_score SHALL register (show_hi ? hiscore : score), i.e. 1 cycle later than its source.
REQ-030 The high score SHALL be compared and captured on the transition into OVER: if score > hiscore, then hiscore <= score and new_hi pulses for 1 cycle; ties SHALL NOT update.

Reset
REQ-031 While clr_n is low: state=IDLE, score=0, hiscore=0, disp_score=0, new_hi=0.
REQ-032 Assertion of clr_n mid-game SHALL abort the game immediately, with no hiscore capture.
REQ-033 After reset release, the block SHALL wait in IDLE for new_game.

Configuration
REQ-034 The macro SCORE_HISCORE_EN SHALL control the high-score feature.
REQ-035 With SCORE_HISCORE_EN defined, hiscore, new_hi and the show_hi selection SHALL be implemented as specified.
REQ-036 With SCORE_HISCORE_EN undefined, there SHALL be no hiscore register, new_hi SHALL be tied 0, show_hi SHALL be ignored and disp_score SHALL follow score.

Structure
REQ-037 The shared package score_pkg SHALL hold the state encodings, the default MAX_SCORE and the default PENALTY.
REQ-038 The saturating add/subtract SHALL be a sub-module named score_sat_update: a pure combinational function of (score, add, sub) to next.

Verification
REQ-039 Reset then new_game, then add 7, add 15, add 3 -> score 7, 22, 25, each exactly 1 cycle after its transfer.
REQ-040 Score 996 with add 15 -> score 999, then add 1 -> score stays 999.
REQ-041 Score 3 with penalty -> 0; score 10 with add 4 and penalty in the same cycle -> 9.
REQ-042 Play to 40, game_over -> new_hi pulse; show_hi=1 -> disp_score 40; second game ending at 40 -> no new_hi.
REQ-043 add_valid held high in OVER -> add_ready=0, score unchanged; after new_game the add lands on score 0.
REQ-044 clr_n asserted mid-game at score 120 -> all outputs 0 and state IDLE asynchronously; hiscore not updated.
